// File: rtl/flag_ctrl_pkg.sv
// Shared definitions for the flag controller: FSM state encodings.
package flag_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SAVE = 2'd1;
  localparam logic [1:0] ST_REST = 2'd2;

endpackage

// File: rtl/flag_ctrl_stack.sv
// LIFO shadow stack of saved flag words. Only the occupancy pointer is reset;
// storage holds whatever was last pushed.
module flag_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx  = AW'(cnt_q);
  assign rd_idx  = AW'(cnt_q - CW'(1));
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_idx];
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o)
      cnt_d = cnt_q + CW'(1);
    else if (pop_i && !empty_o)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/flag_ctrl.sv
// Processor flag register with prioritised update sources (restore, save,
// software write, ALU) and a shadow stack for nested interrupt entry/return.
module flag_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] ENTRY_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [WIDTH-1:0]           alu_flags,
  input  logic [WIDTH-1:0]           alu_mask,
  output logic                       alu_stall,
  input  logic                       sw_req,
  input  logic [WIDTH-1:0]           sw_data,
  output logic                       sw_ack,
  input  logic                       save_req,
  output logic                       save_ack,
  input  logic                       rest_req,
  output logic                       rest_ack,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           flags,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       ovf_err,
  output logic                       unf_err
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             idle, push, pop, full, empty;
  logic [WIDTH-1:0] stk_top;

  flag_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (flags_q),
    .rdata_o (stk_top),
    .full_o  (full),
    .empty_o (empty),
    .count_o (depth)
  );

  assign idle      = (state_q == ST_IDLE);
  assign busy      = ~idle;
  assign save_ack  = (state_q == ST_SAVE);
  assign rest_ack  = (state_q == ST_REST);
  assign sw_ack    = idle & ~rest_req & ~save_req & sw_req;
  assign alu_stall = alu_valid & ~(idle & ~rest_req & ~save_req & ~sw_req);
  assign push      = save_ack & ~full;
  assign pop       = rest_ack & ~empty;

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (rest_req)       state_d = ST_REST;
        else if (save_req)  state_d = ST_SAVE;
        else if (sw_req)    flags_d = sw_data;
        else if (alu_valid) flags_d = (flags_q & ~alu_mask) | (alu_flags & alu_mask);
      end
      ST_SAVE: begin
        state_d = ST_IDLE;
        if (push) flags_d = ENTRY_VAL;
      end
      ST_REST: begin
        state_d = ST_IDLE;
        if (pop) flags_d = stk_top;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new error in the same cycle takes precedence over err_clr.
  assign ovf_d = (save_ack & full)  | (ovf_q & ~err_clr);
  assign unf_d = (rest_ack & empty) | (unf_q & ~err_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign flags   = flags_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Randomised and directed bench for flag_ctrl against a queue-based flag model.
module tb_flag_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] ENTRY = 16'h0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_valid, sw_req, save_req, rest_req, err_clr;
  logic [WIDTH-1:0] alu_flags, alu_mask, sw_data;
  logic             alu_stall, sw_ack, save_ack, rest_ack, busy, ovf_err, unf_err;
  logic [WIDTH-1:0] flags;
  logic [DW-1:0]    depth;

  flag_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ENTRY_VAL(ENTRY)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_flags(alu_flags), .alu_mask(alu_mask), .alu_stall(alu_stall),
    .sw_req(sw_req), .sw_data(sw_data), .sw_ack(sw_ack),
    .save_req(save_req), .save_ack(save_ack),
    .rest_req(rest_req), .rest_ack(rest_ack),
    .err_clr(err_clr), .flags(flags), .depth(depth), .busy(busy),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending operation (0 none, 1 save, 2 restore), flag word,
  // saved words as a queue, sticky errors.
  int               m_op;
  logic [WIDTH-1:0] m_flags;
  logic [WIDTH-1:0] m_stk [$];
  bit               m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit av, input logic [WIDTH-1:0] af, input logic [WIDTH-1:0] am,
                       input bit sw, input logic [WIDTH-1:0] sd,
                       input bit sv, input bit rs, input bit ec);
    alu_valid = av; alu_flags = af; alu_mask = am;
    sw_req = sw; sw_data = sd; save_req = sv; rest_req = rs; err_clr = ec;
  endtask

  task automatic idle_in();
    drive(0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_op = 0; m_flags = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_update();
    bit set_o, set_u;
    set_o = 0; set_u = 0;
    if (m_op == 1) begin
      if (m_stk.size() < DEPTH) begin m_stk.push_back(m_flags); m_flags = ENTRY; end
      else set_o = 1;
      m_op = 0;
    end else if (m_op == 2) begin
      if (m_stk.size() > 0) m_flags = m_stk.pop_back();
      else set_u = 1;
      m_op = 0;
    end else begin
      if (rest_req)       m_op = 2;
      else if (save_req)  m_op = 1;
      else if (sw_req)    m_flags = sw_data;
      else if (alu_valid) m_flags = (m_flags & ~alu_mask) | (alu_flags & alu_mask);
    end
    m_ovf = set_o ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_unf = set_u ? 1'b1 : (err_clr ? 1'b0 : m_unf);
  endtask

  task automatic compare();
    bit idl;
    idl = (m_op == 0);
    check("flags",     flags,     m_flags);
    check("depth",     depth,     m_stk.size());
    check("busy",      busy,      !idl);
    check("save_ack",  save_ack,  m_op == 1);
    check("rest_ack",  rest_ack,  m_op == 2);
    check("sw_ack",    sw_ack,    idl && !rest_req && !save_req && sw_req);
    check("alu_stall", alu_stall, alu_valid && !(idl && !rest_req && !save_req && !sw_req));
    check("ovf_err",   ovf_err,   m_ovf);
    check("unf_err",   unf_err,   m_unf);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic sw_write(input logic [WIDTH-1:0] v);
    drive(0, 16'h0, 16'h0, 1, v, 0, 0, 0); step();
  endtask

  task automatic do_save();
    drive(0, 16'h0, 16'h0, 0, 16'h0, 1, 0, 0); step();
    idle_in(); step();
  endtask

  task automatic do_restore();
    drive(0, 16'h0, 16'h0, 0, 16'h0, 0, 1, 0); step();
    idle_in(); step();
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compare();
    reset = 1'b1;
    @(negedge clk);

    // 1: masked ALU update
    drive(1, 16'hFFFF, 16'h000F, 0, 16'h0, 0, 0, 0); step();
    idle_in(); #1;
    check("t1_flags", flags, 16'h000F);
    step();

    // 2: save then restore round trip
    sw_write(16'h1234);
    do_save();
    check("t2_entry", flags, ENTRY);
    check("t2_depth1", depth, 1);
    do_restore();
    check("t2_back", flags, 16'h1234);
    check("t2_depth0", depth, 0);

    // 3: save preempts software write and ALU; software write lands after
    drive(1, 16'h00FF, 16'hFFFF, 1, 16'hAAAA, 1, 0, 0); step();
    drive(0, 16'h0, 16'h0, 1, 16'hAAAA, 0, 0, 0); step();
    step();
    idle_in(); #1;
    check("t3_sw", flags, 16'hAAAA);
    step();
    do_restore();

    // 4: overflow after DEPTH saves, then LIFO order on restore
    for (int i = 0; i < 5; i++) begin
      sw_write(16'h1000 + 16'(i));
      do_save();
    end
    check("t4_depth", depth, DEPTH);
    check("t4_ovf", ovf_err, 1);
    for (int i = 0; i < 4; i++) begin
      do_restore();
      check("t4_lifo", flags, 16'h1003 - 16'(i));
    end
    drive(0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 1); step();
    idle_in(); #1;
    check("t4_clr", ovf_err, 0);
    step();

    // 5: underflow leaves flags alone, then err_clr
    sw_write(16'h5A5A);
    do_restore();
    check("t5_flags", flags, 16'h5A5A);
    check("t5_unf", unf_err, 1);
    drive(0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 1); step();
    idle_in(); #1;
    check("t5_clr", unf_err, 0);
    step();

    // 6: reset in the middle of a SAVE cycle
    sw_write(16'h7777);
    do_save();
    sw_write(16'h4321);
    drive(0, 16'h0, 16'h0, 0, 16'h0, 1, 0, 0); step();
    idle_in();
    #2;
    reset = 1'b0;
    #1;
    check("t6_ack", save_ack, 0);
    check("t6_busy", busy, 0);
    check("t6_flags", flags, 0);
    check("t6_depth", depth, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom),
            $urandom_range(0, 3) == 0, 16'($urandom),
            $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
